// File: rtl/id_stage_hz_if.sv
// ============================================================================
//  Module      : id_stage_hz_if
//  Description : Bundle of handshake, write-back, hazard-input and decoded
//                output signals of the instruction-decode stage.
//                master modport : the surrounding pipeline (IF / EX / WB side)
//                slave modport  : the decode stage itself
//  Parameters  : XLEN   datapath width
//                AW     register index width
//                SCNT_W stall counter width
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_stage_hz_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int SCNT_W = 16
);
    // Fetch-side handshake
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   NPCi;
    logic [31:0]       IR;
    // Write-back port
    logic              WBFlag;
    logic [AW-1:0]     WBAddr;
    logic [XLEN-1:0]   WBVal;
    // Load-use hazard information from EX
    logic              ex_is_load;
    logic [AW-1:0]     ex_rt;
    logic              flush;
    // Execute-side handshake and decoded outputs
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   NPCo;
    logic [31:0]       IRo;
    logic [XLEN-1:0]   A;
    logic [XLEN-1:0]   B;
    logic [XLEN-1:0]   Imm;
    logic [SCNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, NPCi, IR, WBFlag, WBAddr, WBVal,
               ex_is_load, ex_rt, flush, out_ready,
        input  in_ready, out_valid, NPCo, IRo, A, B, Imm, stall_cnt
    );

    modport slave (
        input  in_valid, NPCi, IR, WBFlag, WBAddr, WBVal,
               ex_is_load, ex_rt, flush, out_ready,
        output in_ready, out_valid, NPCo, IRo, A, B, Imm, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/id_stage_hz.sv
// ============================================================================
//  Module      : id_stage_hz
//  Description : Instruction-decode stage with register file, immediate
//                extension, load-use hazard stall and stall counter.
//                Ports:
//                  clk  - single clock, rising edge
//                  rst  - synchronous active-high reset
//                  bus  - id_stage_hz_if.slave (handshakes, write-back,
//                         hazard inputs, flush, decoded outputs, stall_cnt)
//                Optional feature macro: ID_BYPASS_EN
//                  defined   -> write-back data is forwarded into A/B when
//                               the write-back index matches rs/rt on accept
//                  undefined -> A/B capture the pre-write register value
//                Assumes XLEN >= 27 (26-bit jump target is zero-extended).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_stage_hz #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int SCNT_W = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    id_stage_hz_if.slave bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [SCNT_W-1:0] C_SCNT_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   r_rf_q [NREG];
    logic              r_out_valid_q;
    logic [XLEN-1:0]   r_npc_q;
    logic [31:0]       r_ir_q;
    logic [XLEN-1:0]   r_a_q;
    logic [XLEN-1:0]   r_b_q;
    logic [XLEN-1:0]   r_imm_q;
    logic [SCNT_W-1:0] r_stall_cnt_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [AW-1:0]     w_rs;
    logic [AW-1:0]     w_rt;
    logic [5:0]        w_opcode;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;
    logic [XLEN-1:0]   w_imm_d;
    logic [XLEN-1:0]   w_a_d;
    logic [XLEN-1:0]   w_b_d;

    assign w_rs     = bus.IR[21 +: AW];
    assign w_rt     = bus.IR[16 +: AW];
    assign w_opcode = bus.IR[31:26];

    // Load-use hazard: the load in EX has not produced its value yet.
    assign w_hazard = bus.in_valid && bus.ex_is_load && (bus.ex_rt != '0) &&
                      ((bus.ex_rt == w_rs) || (bus.ex_rt == w_rt));

    // rst is included so that the upstream stage never sees a handshake
    // that would be discarded by the reset.
    assign w_in_ready = !rst && !bus.flush && !w_hazard &&
                        (!r_out_valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Jumps carry a 26-bit target; logical immediates are unsigned;
    // everything else is a signed 16-bit offset/immediate.
    always_comb begin
        w_imm_d = {{(XLEN-16){bus.IR[15]}}, bus.IR[15:0]};
        case (w_opcode)
            6'h02, 6'h03:        w_imm_d = {{(XLEN-26){1'b0}}, bus.IR[25:0]};
            6'h0C, 6'h0D, 6'h0E: w_imm_d = {{(XLEN-16){1'b0}}, bus.IR[15:0]};
            default:             ;
        endcase
    end

    // Operand read. Index 0 is forced to zero even though the entry is
    // never written, so the constant-zero register does not rely on reset.
    always_comb begin
        w_a_d = (w_rs == '0) ? '0 : r_rf_q[w_rs];
        w_b_d = (w_rt == '0) ? '0 : r_rf_q[w_rt];
`ifdef ID_BYPASS_EN
        if (bus.WBFlag && (bus.WBAddr != '0) && (bus.WBAddr == w_rs)) begin
            w_a_d = bus.WBVal;
        end
        if (bus.WBFlag && (bus.WBAddr != '0) && (bus.WBAddr == w_rt)) begin
            w_b_d = bus.WBVal;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf_q[i] <= '0;
            end
            r_out_valid_q <= 1'b0;
            r_npc_q       <= '0;
            r_ir_q        <= '0;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_imm_q       <= '0;
            r_stall_cnt_q <= '0;
        end else begin
            // Write-back proceeds regardless of flush or stall.
            if (bus.WBFlag && (bus.WBAddr != '0)) begin
                r_rf_q[bus.WBAddr] <= bus.WBVal;
            end

            if (bus.flush) begin
                r_out_valid_q <= 1'b0;
            end else if (w_accept) begin
                r_out_valid_q <= 1'b1;
                r_npc_q       <= bus.NPCi;
                r_ir_q        <= bus.IR;
                r_a_q         <= w_a_d;
                r_b_q         <= w_b_d;
                r_imm_q       <= w_imm_d;
            end else if (r_out_valid_q && bus.out_ready) begin
                r_out_valid_q <= 1'b0;
            end

            if (w_hazard && !bus.flush && (r_stall_cnt_q != C_SCNT_MAX)) begin
                r_stall_cnt_q <= r_stall_cnt_q + SCNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid_q;
    assign bus.NPCo      = r_npc_q;
    assign bus.IRo       = r_ir_q;
    assign bus.A         = r_a_q;
    assign bus.B         = r_b_q;
    assign bus.Imm       = r_imm_q;
    assign bus.stall_cnt = r_stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_hz.sv
// ============================================================================
//  Module      : tb_id_stage_hz
//  Description : Self-checking bench for id_stage_hz. A reference model of
//                the register file, handshake and stall counter predicts
//                in_ready each cycle; accepted instructions push their
//                expected decoded outputs onto a scoreboard queue which is
//                popped when the stage presents them.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_stage_hz;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int SCNT_W = 4;
    localparam logic [SCNT_W-1:0] C_SMAX = '1;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } exp_t;

    logic clk;
    logic rst;

    id_stage_hz_if #(.XLEN(XLEN), .AW(AW), .SCNT_W(SCNT_W)) bus ();

    id_stage_hz #(.XLEN(XLEN), .NREG(NREG), .SCNT_W(SCNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]       m_rf [NREG];
    logic              m_ov;
    logic [SCNT_W-1:0] m_stall;
    exp_t              m_last;
    exp_t              sb_q [$];

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] ir);
        case (ir[31:26])
            6'h02, 6'h03:        ext = {6'b0, ir[25:0]};
            6'h0C, 6'h0D, 6'h0E: ext = {16'b0, ir[15:0]};
            default:             ext = {{16{ir[15]}}, ir[15:0]};
        endcase
    endfunction

    task automatic idle();
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.NPCi       = '0;
        bus.IR         = '0;
        bus.WBFlag     = 1'b0;
        bus.WBAddr     = '0;
        bus.WBVal      = '0;
        bus.ex_is_load = 1'b0;
        bus.ex_rt      = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
    endtask

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge.
    task automatic step();
        logic [4:0] rs;
        logic [4:0] rt;
        logic       hz;
        logic       rdy;
        logic       acc;
        exp_t       e;
        #1;
        rs  = bus.IR[25:21];
        rt  = bus.IR[20:16];
        hz  = bus.in_valid && bus.ex_is_load && (bus.ex_rt != 0) &&
              ((bus.ex_rt == rs) || (bus.ex_rt == rt));
        rdy = !rst && !bus.flush && !hz && (!m_ov || bus.out_ready);
        chk("in_ready", bus.in_ready, rdy);
        acc = bus.in_valid && rdy;
        if (acc) begin
            e.npc = bus.NPCi;
            e.ir  = bus.IR;
            e.a   = m_rf[rs];
            e.b   = m_rf[rt];
`ifdef ID_BYPASS_EN
            if (bus.WBFlag && bus.WBAddr != 0 && bus.WBAddr == rs) e.a = bus.WBVal;
            if (bus.WBFlag && bus.WBAddr != 0 && bus.WBAddr == rt) e.b = bus.WBVal;
`endif
            e.imm = ext(bus.IR);
            sb_q.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            m_ov    = 1'b0;
            m_stall = '0;
            m_last  = '0;
            sb_q.delete();
        end else begin
            if (bus.WBFlag && bus.WBAddr != 0) m_rf[bus.WBAddr] = bus.WBVal;
            if (bus.flush)                    m_ov = 1'b0;
            else if (acc)                     m_ov = 1'b1;
            else if (m_ov && bus.out_ready)   m_ov = 1'b0;
            if (hz && !bus.flush && m_stall != C_SMAX) m_stall = m_stall + 1'b1;
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) m_last = sb_q.pop_front();
        chk("out_valid", bus.out_valid, m_ov);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("NPCo",      bus.NPCo,      m_last.npc);
        chk("IRo",       bus.IRo,       m_last.ir);
        chk("A",         bus.A,         m_last.a);
        chk("B",         bus.B,         m_last.b);
        chk("Imm",       bus.Imm,       m_last.imm);
        @(negedge clk);
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] val);
        idle();
        bus.WBFlag = 1'b1;
        bus.WBAddr = addr;
        bus.WBVal  = val;
        step();
    endtask

    task automatic issue(input logic [31:0] npc, input logic [31:0] ir);
        idle();
        bus.in_valid = 1'b1;
        bus.NPCi     = npc;
        bus.IR       = ir;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_ov    = 1'b0;
        m_stall = '0;
        m_last  = '0;
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        idle();
        @(negedge clk);

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", bus.out_valid, 1'b0);

        // Write r5, read it through both operands
        wb(5'd5, 32'h1234);
        issue(32'h100, 32'h00A53020);
        chk("r5_A", bus.A, 32'h1234);
        chk("r5_B", bus.B, 32'h1234);

        // Immediate extension variants
        issue(32'h104, 32'h3402FFFF);
        chk("ori_imm", bus.Imm, 32'h0000FFFF);
        issue(32'h108, 32'h2002FFFF);
        chk("addi_imm", bus.Imm, 32'hFFFFFFFF);
        issue(32'h10C, 32'h0C000010);
        chk("jal_imm", bus.Imm, 32'h00000010);
        idle();
        step();

        // Load-use hazard for three cycles, then ex_rt=0 clears it
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.in_valid   = 1'b1;
            bus.IR         = 32'h00A00000;
            bus.NPCi       = 32'h200;
            bus.ex_is_load = 1'b1;
            bus.ex_rt      = 5'd5;
            step();
        end
        chk("stall3", bus.stall_cnt, 4'd3);
        bus.ex_rt = 5'd0;
        step();
        chk("no_stall_accept", bus.out_valid, 1'b1);

        // Write-back coincident with accept of rs=7
        wb(5'd7, 32'h1111);
        idle();
        bus.in_valid = 1'b1;
        bus.NPCi     = 32'h300;
        bus.IR       = 32'h00E00000;
        bus.WBFlag   = 1'b1;
        bus.WBAddr   = 5'd7;
        bus.WBVal    = 32'hCAFE;
        step();
`ifdef ID_BYPASS_EN
        chk("bypass_A", bus.A, 32'hCAFE);
`else
        chk("nobypass_A", bus.A, 32'h1111);
`endif

        // Back-pressure: outputs frozen for four cycles, then flush
        issue(32'h400, 32'h2004ABCD);
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.in_valid  = 1'b1;
            bus.NPCi      = 32'h404 + i;
            bus.IR        = 32'h3408_0000 + i;
            bus.out_ready = 1'b0;
            step();
        end
        chk("frozen_NPCo", bus.NPCo, 32'h400);
        idle();
        bus.in_valid  = 1'b1;
        bus.IR        = 32'h34080055;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        step();
        chk("flush_out_valid", bus.out_valid, 1'b0);

        // Reset mid-stream with a coincident write-back to r3
        wb(5'd3, 32'h33);
        issue(32'h500, 32'h00630000);
        idle();
        rst          = 1'b1;
        bus.WBFlag   = 1'b1;
        bus.WBAddr   = 5'd3;
        bus.WBVal    = 32'h99;
        bus.in_valid = 1'b1;
        bus.IR       = 32'h00630000;
        step();
        chk("rst_stall", bus.stall_cnt, 4'd0);
        issue(32'h504, 32'h00630000);
        chk("r3_after_rst", bus.A, 32'h0);

        // Randomised traffic with hazards, flushes, back-pressure, resets
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 5))
                0:       op = 6'h02;
                1:       op = 6'h03;
                2:       op = 6'h0C;
                3:       op = 6'h0D;
                4:       op = 6'h0E;
                default: op = 6'($urandom);
            endcase
            rst            = ($urandom_range(0, 79) == 0);
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.NPCi       = $urandom;
            bus.IR         = {op, 2'b00, 3'($urandom), 2'b00, 3'($urandom), 16'($urandom)};
            bus.WBFlag     = ($urandom_range(0, 1) != 0);
            bus.WBAddr     = 5'($urandom_range(0, 7));
            bus.WBVal      = $urandom;
            bus.ex_is_load = ($urandom_range(0, 2) == 0);
            bus.ex_rt      = 5'($urandom_range(0, 7));
            bus.flush      = ($urandom_range(0, 15) == 0);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_stage_hz.md
ID_STAGE_HZ -- requirements
Module: id_stage_hz

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register file, NPC, A, B, Imm.
REQ-002 Parameter NREG, default 32, register count; power of two, 2..32; AW = log2(NREG).
REQ-003 Parameter SCNT_W, default 16, stall counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  IF stage presents NPCi/IR.
REQ-007 in_ready  out  1  stage accepts NPCi/IR this cycle.
REQ-008 NPCi  in  XLEN  next-PC of incoming instruction.
REQ-009 IR  in  32  incoming instruction word.
REQ-010 WBFlag  in  1  write-back enable; WBAddr  in  AW  target register; WBVal  in  XLEN  write data.
REQ-011 ex_is_load  in  1  EX-stage instruction is a load; ex_rt  in  AW  its destination.
REQ-012 flush  in  1  discard the held output and the incoming instruction.
REQ-013 out_valid  out  1  outputs hold a decoded instruction; out_ready  in  1  EX accepts it.
REQ-014 NPCo  out  XLEN, IRo  out  32, A  out  XLEN (rs value), B  out  XLEN (rt value), Imm  out  XLEN (extended immediate).
REQ-015 stall_cnt  out  SCNT_W  count of hazard-stall cycles.

Function
REQ-016 Register file NREG x XLEN; read of index 0 returns 0; writes to index 0 ignored; write occurs at edge when WBFlag=1.
REQ-017 rs = IR[21+AW-1:21], rt = IR[16+AW-1:16], opcode = IR[31:26].
REQ-018 hazard = in_valid & ex_is_load & (ex_rt!=0) & (ex_rt==rs | ex_rt==rt), combinational.
REQ-019 in_ready = !flush & !hazard & (!out_valid | out_ready).
REQ-020 Accept (in_valid & in_ready): at next edge NPCo<=NPCi, IRo<=IR, A<=rf[rs], B<=rf[rt], Imm<=ext(IR), out_valid<=1; latency one cycle.
REQ-021 ext: opcode 0x02/0x03 -> zero-extend IR[25:0]; opcode 0x0C/0x0D/0x0E -> zero-extend IR[15:0]; all others -> sign-extend IR[15:0].
REQ-022 out_valid & out_ready without accept -> out_valid<=0; data outputs keep last value.
REQ-023 out_valid & !out_ready -> all outputs stable until out_ready.
REQ-024 flush=1 -> out_valid<=0 next edge; no accept that cycle; register file writes still performed; flush overrides hazard and accept.
REQ-025 Each cycle with hazard=1 and flush=0 increments stall_cnt; saturates at 2^SCNT_W-1.
REQ-026 Read-during-write same index, same edge, without bypass: captured A/B hold pre-write value.

Reset
REQ-027 rst=1 at edge: out_valid=0, NPCo=IRo=A=B=Imm=0, stall_cnt=0, all registers cleared to 0.
REQ-028 rst dominates flush, accept and WBFlag; a write-back coincident with rst is dropped.
REQ-029 in_ready is 0 while rst=1.

Configuration
REQ-030 Macro ID_BYPASS_EN defined: on accept, if WBFlag & WBAddr!=0 & WBAddr==rs then A<=WBVal; same rule for rt into B.
REQ-031 Macro ID_BYPASS_EN undefined: no bypass; REQ-026 applies; hazard logic unchanged.

Verification
REQ-032 After reset, WB r5=0x1234 then accept IR=0x00A53020 (rs=5,rt=5) -> next cycle A=B=0x1234, out_valid=1.
REQ-033 IR=0x3402FFFF (ori) -> Imm=0x0000FFFF; IR=0x2002FFFF (addi) -> Imm=0xFFFFFFFF; IR=0x0C000010 (jal) -> Imm=0x00000010.
REQ-034 ex_is_load=1, ex_rt=5, IR reads rs=5 for 3 cycles -> in_ready=0 three cycles, stall_cnt=3; ex_rt=0 -> no stall.
REQ-035 WBFlag=1 WBAddr=7 WBVal=0xCAFE while accepting rs=7 -> A=0xCAFE with ID_BYPASS_EN, old r7 without.
REQ-036 out_valid=1, out_ready=0 for 4 cycles -> outputs frozen, in_ready=0; then flush=1 -> out_valid=0 next cycle.
REQ-037 rst pulsed mid-stream with WBFlag=1 WBAddr=3 -> r3 reads 0, out_valid=0, stall_cnt=0.
